// File: rtl/dark_bus_initiator.sv
// Single-outstanding initiator for the XDREQ/XWR/XRD/XDACK peripheral bus.
// A command goes out on the bus one cycle after it is accepted. The result comes back once XDACK arrives or the timeout expires.
module dark_bus_initiator #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_vld_i,
  output logic        cmd_rdy_o,
  input  logic        cmd_wr_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_data_i,
  input  logic [3:0]  cmd_be_i,
  output logic        rsp_vld_o,
  input  logic        rsp_rdy_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        xdreq_o,
  output logic        xwr_o,
  output logic        xrd_o,
  output logic [3:0]  xbe_o,
  output logic [31:0] xaddr_o,
  output logic [31:0] xatao_o,
  input  logic [31:0] xatai_i,
  input  logic        xdack_i
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  localparam bit         TO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic [7:0]  timer_q, timer_d;
  logic [31:0] rsp_data_q;
  logic        rsp_err_q;
  logic        xdreq_q, xwr_q, xrd_q;
  logic [3:0]  xbe_q;
  logic [31:0] xaddr_q, xatao_q;
  logic        timeout_hit;

  // Saturating so a long wait with the timeout disabled never wraps.
  always_comb begin
    timer_d = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;
  end

  assign timeout_hit = TO_EN && (timer_q == TO_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      xdreq_q    <= 1'b0;
      xwr_q      <= 1'b0;
      xrd_q      <= 1'b0;
      xbe_q      <= '0;
      xaddr_q    <= '0;
      xatao_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_vld_i) begin
            state_q <= REQ;
            timer_q <= '0;
            xdreq_q <= 1'b1;
            xwr_q   <= cmd_wr_i;
            xrd_q   <= !cmd_wr_i;
            xbe_q   <= cmd_be_i;
            xaddr_q <= cmd_addr_i;
            xatao_q <= cmd_data_i;
          end
        end
        REQ: begin
          // An acknowledge in the final timeout cycle still completes normally.
          if (xdack_i || timeout_hit) begin
            state_q    <= RSP;
            rsp_data_q <= (xdack_i && xrd_q) ? xatai_i : '0;
            rsp_err_q  <= !xdack_i;
            xdreq_q    <= 1'b0;
            xwr_q      <= 1'b0;
            xrd_q      <= 1'b0;
            xbe_q      <= '0;
            xaddr_q    <= '0;
            xatao_q    <= '0;
          end else begin
            timer_q <= timer_d;
          end
        end
        RSP: begin
          if (rsp_rdy_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_rdy_o  = (state_q == IDLE);
  assign rsp_vld_o  = (state_q == RSP);
  assign rsp_data_o = rsp_data_q;
  assign rsp_err_o  = rsp_err_q;
  assign xdreq_o    = xdreq_q;
  assign xwr_o      = xwr_q;
  assign xrd_o      = xrd_q;
  assign xbe_o      = xbe_q;
  assign xaddr_o    = xaddr_q;
  assign xatao_o    = xatao_q;

endmodule

// File: doc/dark_bus_initiator.md
# dark_bus_initiator

Single-outstanding bus initiator for the XDREQ/XWR/XRD/XDACK peripheral bus, the requesting end of the interface served by the IO block. It accepts word commands on a valid/ready port, drives one bus transaction at a time, waits for the responder's XDACK, and returns read data or a timeout error on a valid/ready response port. Used by debug and bring-up logic that must reach IO registers (LED, timer, OPORT, UART, SPI) without the core.

## Interface
- TIMEOUT, 15: max cycles XDREQ stays asserted without XDACK before abort; 0 disables timeout; max 255.
- CLK  in  1  clock; all state on rising edge.
- RES  in  1  reset; asynchronous and active-high.
- CMD_VLD  in  1  command valid.
- CMD_RDY  out  1  command accepted when CMD_VLD && CMD_RDY.
- CMD_WR  in  1  1 = write, 0 = read.
- CMD_ADDR  in  32  bus address.
- CMD_DATA  in  32  write data; ignored for reads.
- CMD_BE  in  4  byte enables, passed through for reads and writes.
- RSP_VLD  out  1  response valid; held until RSP_RDY.
- RSP_RDY  in  1  response consumed when RSP_VLD && RSP_RDY.
- RSP_DATA  out  32  read data; 0 for writes and for timeouts.
- RSP_ERR  out  1  1 = transaction timed out.
- XDREQ  out  1  bus request.
- XWR  out  1  write strobe, qualified by XDREQ.
- XRD  out  1  read strobe, qualified by XDREQ.
- XBE  out  4  byte enables.
- XADDR  out  32  address.
- XATAO  out  32  write data (to responder data input).
- XATAI  in  32  read data (from responder data output).
- XDACK  in  1  responder acknowledge.

## Operation
- States: IDLE, REQ, RSP.
- IDLE: CMD_RDY=1, all bus outputs 0. On CMD_VLD: register CMD_WR/ADDR/DATA/BE, go to REQ; XDREQ and XWR or XRD are high from the next cycle.
- REQ: XDREQ=1, exactly one of XWR/XRD=1, XADDR/XBE/XATAO stable. Timer counts up from 0 each REQ cycle.
  - XDACK=1 sampled: latch XATAI into RSP_DATA if read (0 if write), RSP_ERR=0, go to RSP.
  - else if TIMEOUT!=0 and timer==TIMEOUT-1: RSP_DATA=0, RSP_ERR=1, go to RSP.
  - XDACK and timeout in the same cycle: XDACK wins, RSP_ERR=0.
- RSP: RSP_VLD=1, bus outputs 0, CMD_RDY=0. On RSP_RDY go to IDLE.
- XDACK outside REQ ignored. XWR and XRD never both high. CMD_RDY=0 in REQ and RSP (no queuing).
- Timer 8 bits, cleared on entry to REQ, saturates; no wrap.
- Reset (any state, any time): state IDLE, timer 0, RSP_DATA 0, registered command 0. Reset values: CMD_RDY=1 (once RES low), RSP_VLD=0, RSP_ERR=0, RSP_DATA=0, XDREQ=XWR=XRD=0, XBE=0, XADDR=0, XATAO=0. Mid-transaction reset drops XDREQ immediately; no response produced.

## Timing
- All outputs registered; no combinational path from any input to any output except CMD_RDY/RSP_VLD decoded directly from state flops.
- Accept at edge N -> XDREQ high cycles N+1..K, K = first cycle with XDACK=1; XDREQ low from K+1.
- Write to a same-cycle acking responder: XDREQ high exactly 1 cycle; RSP_VLD at cycle N+2.
- Read to a responder acking one cycle after request: XDREQ high 2 cycles; XATAI sampled at the acking cycle; RSP_VLD at N+3.
- Timeout: XDREQ high exactly TIMEOUT cycles; RSP_VLD the next cycle.
- XDREQ is low for at least 2 cycles between transactions (RSP + IDLE), so a responder wait-state counter always drains.
- Back-to-back with RSP_RDY tied high: one transaction per (bus cycles + 2) cycles.

## Test plan
- Write CMD_ADDR=0x08, DATA=0x0000_00A5, BE=0xF to a responder with XDACK=XDREQ&&XWR -> XDREQ/XWR high 1 cycle, XADDR=0x08, XATAO=0xA5; RSP_VLD, RSP_DATA=0, RSP_ERR=0.
- Read 0x14 with responder returning 0x1234_5678 one cycle after request -> XDREQ/XRD high 2 cycles; RSP_DATA=0x1234_5678, RSP_ERR=0.
- Read with XDACK never asserted, TIMEOUT=15 -> XDREQ high exactly 15 cycles then low; RSP_ERR=1, RSP_DATA=0. TIMEOUT=0 -> XDREQ stays high 1000 cycles, no response.
- XDACK on cycle 15 of a TIMEOUT=15 read, XATAI=0xCAFE_0001 -> RSP_ERR=0, RSP_DATA=0xCAFE_0001.
- RSP_RDY held low 10 cycles with CMD_VLD high -> RSP_VLD and RSP_DATA stable, CMD_RDY=0, XDREQ=0 throughout; second command accepted the cycle after RSP_RDY.
- RES pulsed while XDREQ=1 (between edges) -> XDREQ/XRD/XADDR drop to 0 without a clock edge; no RSP_VLD; next command completes normally.
